// File: rtl/mult_packed_result_accumulator.sv
// Purpose: unpack the 8x4 multiplier's product word into one or two lanes and sum each lane over a group of beats.
// Latency: a group's result is registered on out_* one cycle after its closing beat is accepted.
// Backpressure: in_ready falls while a result is held and rises the cycle after out_valid & out_ready.
module mult_packed_result_accumulator #(
    parameter int C_WIDTH    = 12,
    parameter int LANE_WIDTH = C_WIDTH / 2,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [C_WIDTH-1:0]   C,
    input  logic                 HALF_0,
    input  logic                 HALF_1,
    input  logic                 C_sign,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc0,
    output logic [ACC_WIDTH-1:0] out_acc1,
    output logic                 out_half,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 err_mode
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state;
    logic                   mode_half;
    logic [ACC_WIDTH-1:0]   acc0;
    logic [ACC_WIDTH-1:0]   acc1;
    logic [CNT_WIDTH-1:0]   cnt;

    logic                   accept;
    logic                   beat_ok;
    logic                   group_live;
    logic                   group_half;
    logic [ACC_WIDTH-1:0]   ext_full;
    logic [ACC_WIDTH-1:0]   ext_l0;
    logic [ACC_WIDTH-1:0]   ext_l1;
    logic [ACC_WIDTH-1:0]   add0;
    logic [ACC_WIDTH-1:0]   add1;
    logic [ACC_WIDTH-1:0]   sum0;
    logic [ACC_WIDTH-1:0]   sum1;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    // Decoded from registered state only, so it never depends on this cycle's inputs.
    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;

    // A beat counts if its mode is legal (exactly one HALF bit) and, mid-group, matches the latched mode.
    always_comb begin
        beat_ok    = (HALF_1 ^ HALF_0) & ((state == IDLE) | (HALF_1 == mode_half));
        group_live = beat_ok | (state == ACCUM);
        group_half = (state == IDLE) ? HALF_1 : mode_half;
    end

    // Lane extraction and sign/zero extension; the lane-1 addend is zero in full mode.
    always_comb begin
        ext_full = {{(ACC_WIDTH-C_WIDTH){C_sign & C[C_WIDTH-1]}}, C};
        ext_l0   = {{(ACC_WIDTH-LANE_WIDTH){C_sign & C[C_WIDTH-1]}}, C[C_WIDTH-1:LANE_WIDTH]};
        ext_l1   = {{(ACC_WIDTH-LANE_WIDTH){C_sign & C[LANE_WIDTH-1]}}, C[LANE_WIDTH-1:0]};
        add0     = HALF_1 ? ext_l0 : ext_full;
        add1     = HALF_1 ? ext_l1 : '0;
        sum0     = acc0 + add0;
        sum1     = acc1 + add1;
        cnt_inc  = (&cnt) ? cnt : cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    // Group state machine: accumulate accepted legal beats, publish on last, hold until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mode_half <= 1'b0;
            acc0      <= '0;
            acc1      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_acc0  <= '0;
            out_acc1  <= '0;
            out_half  <= 1'b0;
            out_count <= '0;
            err_mode  <= 1'b0;
        end else begin
            err_mode <= accept & ~beat_ok;
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (in_last && group_live) begin
                            out_acc0  <= beat_ok ? sum0 : acc0;
                            out_acc1  <= beat_ok ? sum1 : acc1;
                            out_count <= beat_ok ? cnt_inc : cnt;
                            out_half  <= group_half;
                            out_valid <= 1'b1;
                            acc0      <= '0;
                            acc1      <= '0;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else if (in_last) begin
                            // Dropped closing beat on an empty group: nothing to publish.
                            state <= IDLE;
                        end else if (beat_ok) begin
                            acc0      <= sum0;
                            acc1      <= sum1;
                            cnt       <= cnt_inc;
                            mode_half <= group_half;
                            state     <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_packed_result_accumulator.sv
module tb_mult_packed_result_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] C;
    logic        HALF_0;
    logic        HALF_1;
    logic        C_sign;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_acc0;
    logic [23:0] out_acc1;
    logic        out_half;
    logic [7:0]  out_count;
    logic        err_mode;

    int n_tests = 0;
    int n_fail  = 0;
    int n_err_seen = 0;

    mult_packed_result_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .HALF_0    (HALF_0),
        .HALF_1    (HALF_1),
        .C_sign    (C_sign),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc0  (out_acc0),
        .out_acc1  (out_acc1),
        .out_half  (out_half),
        .out_count (out_count),
        .err_mode  (err_mode)
    );

    always #5 clk = ~clk;

    // Reference model: a group is a list of counted beats summed with signed integer arithmetic.
    bit     m_hold;
    int     m_n;
    longint m_s0;
    longint m_s1;
    bit     m_half;
    bit     m_err;
    longint m_o0;
    longint m_o1;
    bit     m_oh;
    int     m_oc;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic longint field_val(input int raw, input int bits, input bit sgn);
        longint v = raw;
        if (sgn && raw >= (1 << (bits - 1))) v = v - (longint'(1) << bits);
        return v;
    endfunction

    task automatic model_step(input bit v, input logic [11:0] c, input logic [1:0] h,
                              input bit s, input bit l, input bit ordy, input bit rst);
        bit ok;
        m_err = 1'b0;
        if (rst) begin
            m_hold = 0; m_n = 0; m_s0 = 0; m_s1 = 0; m_half = 0;
            m_o0 = 0; m_o1 = 0; m_oh = 0; m_oc = 0;
        end else if (m_hold) begin
            if (ordy) m_hold = 0;
        end else if (v) begin
            ok = (h == 2'b01 || h == 2'b10) && (m_n == 0 || h[1] == m_half);
            if (ok) begin
                if (m_n == 0) m_half = h[1];
                if (h[1]) begin
                    m_s0 += field_val(int'(c[11:6]), 6, s);
                    m_s1 += field_val(int'(c[5:0]), 6, s);
                end else begin
                    m_s0 += field_val(int'(c), 12, s);
                end
                m_n++;
            end else begin
                m_err = 1'b1;
            end
            if (l && m_n > 0) begin
                m_o0 = m_s0 & 64'hFF_FFFF;
                m_o1 = m_s1 & 64'hFF_FFFF;
                m_oh = m_half;
                m_oc = (m_n > 255) ? 255 : m_n;
                m_hold = 1;
                m_n = 0; m_s0 = 0; m_s1 = 0;
            end
        end
    endtask

    task automatic check_all();
        check("in_ready",  in_ready,  !m_hold);
        check("out_valid", out_valid, m_hold);
        check("out_acc0",  out_acc0,  m_o0);
        check("out_acc1",  out_acc1,  m_o1);
        check("out_half",  out_half,  m_oh);
        check("out_count", out_count, m_oc);
        check("err_mode",  err_mode,  m_err);
        if (err_mode) n_err_seen++;
    endtask

    task automatic cyc(input bit v, input logic [11:0] c, input logic [1:0] h,
                       input bit s, input bit l, input bit ordy, input bit rst);
        in_valid = v; C = c; {HALF_1, HALF_0} = h; C_sign = s;
        in_last = l; out_ready = ordy; reset = rst;
        @(posedge clk);
        model_step(v, c, h, s, l, ordy, rst);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [1:0] pref;
        logic [1:0] hh;
        int r;

        in_valid = 0; C = '0; HALF_0 = 0; HALF_1 = 0; C_sign = 0;
        in_last = 0; out_ready = 0; reset = 1;
        @(negedge clk);

        // Reset state
        cyc(0, 12'h000, 2'b00, 0, 0, 0, 1);
        cyc(0, 12'h000, 2'b00, 0, 0, 0, 0);

        // T1 full unsigned, then T4 backpressure with beats offered while held
        cyc(1, 12'h0F0, 2'b01, 0, 0, 0, 0);
        cyc(1, 12'h0F0, 2'b01, 0, 0, 0, 0);
        cyc(1, 12'h0F0, 2'b01, 0, 1, 0, 0);
        check("t1_acc0", out_acc0, 720);
        check("t1_acc1", out_acc1, 0);
        check("t1_count", out_count, 3);
        check("t1_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) cyc(1, 12'h3FF, 2'b01, 0, 1, 0, 0);
        check("t4_in_ready_held", in_ready, 0);
        check("t4_acc0_stable", out_acc0, 720);
        cyc(0, 12'h000, 2'b01, 0, 0, 1, 0);
        check("t4_released_valid", out_valid, 0);
        check("t4_released_ready", in_ready, 1);

        // T2 half signed
        cyc(1, 12'hF83, 2'b10, 1, 0, 1, 0);
        cyc(1, 12'hF83, 2'b10, 1, 1, 1, 0);
        check("t2_acc0", out_acc0, 24'hFFFFFC);
        check("t2_acc1", out_acc1, 6);
        check("t2_half", out_half, 1);
        cyc(0, 12'h000, 2'b10, 0, 0, 1, 0);

        // T3 half unsigned
        cyc(1, 12'hF83, 2'b10, 0, 0, 1, 0);
        cyc(1, 12'hF83, 2'b10, 0, 1, 0, 0);
        check("t3_acc0", out_acc0, 124);
        check("t3_acc1", out_acc1, 6);
        cyc(0, 12'h000, 2'b10, 0, 0, 1, 0);

        // T5 illegal and mismatched beats inside a full group
        n_err_seen = 0;
        cyc(1, 12'h010, 2'b01, 0, 0, 1, 0);
        cyc(1, 12'h7FF, 2'b11, 0, 0, 1, 0);
        cyc(1, 12'h7FF, 2'b10, 0, 0, 1, 0);
        cyc(1, 12'h010, 2'b01, 0, 1, 0, 0);
        check("t5_err_pulses", n_err_seen, 2);
        check("t5_acc0", out_acc0, 32);
        check("t5_count", out_count, 2);
        cyc(0, 12'h000, 2'b01, 0, 0, 1, 0);

        // Dropped closing beat on an empty group emits nothing
        cyc(1, 12'h123, 2'b00, 0, 1, 1, 0);
        check("empty_last_no_valid", out_valid, 0);

        // T6 reset mid-group
        cyc(1, 12'h100, 2'b01, 0, 0, 1, 0);
        cyc(1, 12'h100, 2'b01, 0, 0, 1, 0);
        cyc(0, 12'h000, 2'b01, 0, 0, 1, 1);
        cyc(0, 12'h000, 2'b01, 0, 0, 1, 0);
        check("t6_no_valid", out_valid, 0);
        cyc(1, 12'h005, 2'b01, 0, 1, 0, 0);
        check("t6_acc0", out_acc0, 5);
        check("t6_count", out_count, 1);
        cyc(0, 12'h000, 2'b01, 0, 0, 1, 0);

        // Counter saturation: 300 beats
        for (int i = 0; i < 299; i++) cyc(1, 12'h001, 2'b01, 0, 0, 1, 0);
        cyc(1, 12'h001, 2'b01, 0, 1, 0, 0);
        check("sat_count", out_count, 255);
        check("sat_acc0", out_acc0, 300);
        cyc(0, 12'h000, 2'b01, 0, 0, 1, 0);

        // Randomized traffic against the model, including occasional resets
        pref = 2'b01;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      hh = 2'b00;
            else if (r == 1) hh = 2'b11;
            else if (r < 4)  hh = ~pref;
            else             hh = pref;
            if ($urandom_range(0, 15) == 0) pref = ~pref;
            cyc($urandom_range(0, 9) < 7, 12'($urandom), hh, 1'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
                $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
